// File: rtl/avg_pkg.sv
// Shared types and constants for the moving-average window controller.
package avg_pkg;

  localparam int AVG_DATA_W = 8;
  localparam int AVG_LOG2_N = 3;
  localparam int AVG_SUM_W  = AVG_DATA_W + AVG_LOG2_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } avg_state_e;

endpackage

// File: rtl/avg_window_ctrl_if.sv
// Sample-in / average-out handshake bundle for avg_window_ctrl.
interface avg_window_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_num;
  logic [DATA_W-1:0] avg8;
  logic              out_valid;
  logic              busy;

  modport master (
    output in_valid, in_num,
    input  in_ready, avg8, out_valid, busy
  );

  modport slave (
    input  in_valid, in_num,
    output in_ready, avg8, out_valid, busy
  );
endinterface

// File: rtl/avg_window_mux.sv
// N:1 window entry select feeding the shared accumulator adder.
module avg_window_mux #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 3
) (
  input  logic [(2**LOG2_N)-1:0][DATA_W-1:0] win_i,
  input  logic [LOG2_N-1:0]                  sel_i,
  output logic [DATA_W-1:0]                  entry_o
);
  assign entry_o = win_i[sel_i];
endmodule

// File: rtl/avg_window_ctrl.sv
// Start/busy/done sequencer for an 8-entry moving average with one shared adder.
// Define AVG_ROUND_EN to round the mean half up instead of truncating.
module avg_window_ctrl
  import avg_pkg::*;
#(
  parameter int DATA_W = AVG_DATA_W,
  parameter int LOG2_N = AVG_LOG2_N
) (
  input  logic          clk,
  input  logic          rs,
  avg_window_ctrl_if.slave bus
);
  localparam int N     = 2 ** LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;

  avg_state_e                  state_q, state_d;
  logic [N-1:0][DATA_W-1:0]    win_q;
  logic [SUM_W-1:0]            acc_q, acc_d;
  logic [LOG2_N-1:0]           idx_q, idx_d;
  logic [DATA_W-1:0]           avg_q, avg_d;
  logic                        out_valid_q;
  logic                        shift_s;
  logic [DATA_W-1:0]           entry_s;
  logic [SUM_W-1:0]            mean_src_s;

  avg_window_mux #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_mux (
    .win_i   (win_q),
    .sel_i   (idx_q),
    .entry_o (entry_s)
  );

`ifdef AVG_ROUND_EN
  // Half-LSB bias; worst case 2040 + 4 still fits in SUM_W.
  assign mean_src_s = acc_q + SUM_W'(N / 2);
`else
  assign mean_src_s = acc_q;
`endif

  // Next-state, accumulate and output-latch decisions.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    avg_d   = avg_q;
    shift_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          shift_s = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + SUM_W'(entry_s);
        idx_d = idx_q + LOG2_N'(1);
        if (idx_q == LOG2_N'(N - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        avg_d   = DATA_W'(mean_src_s >> LOG2_N);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, window, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rs) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      avg_q       <= avg_d;
      out_valid_q <= (state_q == ST_DONE);
      if (shift_s) begin
        for (int k = 0; k < N - 1; k++) begin
          win_q[k] <= win_q[k+1];
        end
        win_q[N-1] <= bus.in_num;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.avg8      = avg_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_avg_window_ctrl.sv
// Directed, table-driven bench for avg_window_ctrl (both AVG_ROUND_EN builds).
module tb_avg_window_ctrl;
  logic clk;
  logic rs;
  int   errors;
  int   checks;

  avg_window_ctrl_if #(.DATA_W(8)) bus ();

  avg_window_ctrl dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    logic [7:0] sample;
    logic [7:0] exp_trunc;
    logic [7:0] exp_round;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input vec_t v);
`ifdef AVG_ROUND_EN
    return int'(v.exp_round);
`else
    return int'(v.exp_trunc);
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rs = 1'b1;
    repeat (2) @(negedge clk);
    rs = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where out_valid should be high.
  task automatic send(input logic [7:0] v, input int exp, input string tag);
    int tmo;
    int good;
    bus.in_valid = 1'b1;
    bus.in_num   = v;
    tmo = 0;
    while (!bus.in_ready && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    chk({tag, "_ready_wait"}, int'(tmo < 20), 1);
    @(posedge clk);
    good = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (!bus.in_ready && bus.busy && !bus.out_valid) good++;
    end
    chk({tag, "_busy_cycles"}, good, 9);
    @(negedge clk);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_ready_back"}, int'(bus.in_ready), 1);
    chk({tag, "_avg8"}, int'(bus.avg8), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ovc;
    int rdy;
    errors = 0;
    checks = 0;
    rs = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_num   = 8'd0;

    vecs[0] = '{1'b1, 8'd80, 8'd10, 8'd10};
    vecs[1] = '{1'b1, 8'd12, 8'd1, 8'd2};
    for (int k = 0; k < 8; k++) begin
      vecs[2+k] = '{(k == 0), 8'd8, 8'(k + 1), 8'(k + 1)};
    end
    vecs[10] = '{1'b0, 8'd255, 8'd38, 8'd39};
    vecs[11] = '{1'b0, 8'd255, 8'd69, 8'd70};
    vecs[12] = '{1'b0, 8'd255, 8'd100, 8'd101};
    vecs[13] = '{1'b0, 8'd255, 8'd131, 8'd132};
    vecs[14] = '{1'b0, 8'd255, 8'd162, 8'd162};
    vecs[15] = '{1'b0, 8'd255, 8'd193, 8'd193};
    vecs[16] = '{1'b0, 8'd255, 8'd224, 8'd224};
    vecs[17] = '{1'b0, 8'd255, 8'd255, 8'd255};

    do_reset();
    chk("rst_avg8", int'(bus.avg8), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].do_rst) begin
        do_reset();
      end
      send(vecs[i].sample, pick(vecs[i]), $sformatf("vec%0d", i));
    end
    @(negedge clk);
    chk("pulse_one_cycle", int'(bus.out_valid), 0);
    chk("avg8_held", int'(bus.avg8), 255);

    // Sample offered while busy must wait; the source holds 50 throughout.
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_num   = 8'd80;
    @(posedge clk);
    rdy = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.in_num = 8'd50;
      if (bus.in_ready) rdy++;
    end
    chk("busy_no_ready", rdy, 0);
    @(negedge clk);
    chk("busy_ignored_avg", int'(bus.avg8), 10);
    chk("busy_ignored_ov", int'(bus.out_valid), 1);
    send(8'd50, 16, "held50");

    // Reset during ACCUM discards the partial sum; reset beats in_valid.
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_num   = 8'd80;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", int'(bus.busy), 1);
    rs = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_num   = 8'd99;
    @(negedge clk);
    rs = 1'b0;
    bus.in_valid = 1'b0;
    ovc = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) ovc++;
      @(negedge clk);
    end
    chk("rst_mid_no_ov", ovc, 0);
    chk("rst_mid_avg8", int'(bus.avg8), 0);
    chk("rst_mid_ready", int'(bus.in_ready), 1);
    send(8'd40, 5, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
